// File: rtl/mem_ctrl_multi.sv
// mem_ctrl_multi: round-robin arbiter that serialises NCH load/store channels onto one byte-wide RAM port.
// Supports 1/2/4-byte transfers, sign-extended loads, IO-window store back-pressure and flush of flushable loads.
module mem_ctrl_multi #(
   parameter int NCH   = 2,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 io_buffer_full,
   input  logic                 flush,
   input  logic [7:0]           mem_din,
   output logic [7:0]           mem_dout,
   output logic [31:0]          mem_a,
   output logic                 mem_wr,
   input  logic [NCH-1:0]       req_valid,
   input  logic [NCH*32-1:0]    req_addr,
   input  logic [NCH*32-1:0]    req_wdata,
   input  logic [NCH*2-1:0]     req_size,
   input  logic [NCH-1:0]       req_we,
   input  logic [NCH-1:0]       req_signed,
   input  logic [NCH*TAG_W-1:0] req_tag,
   input  logic [NCH-1:0]       req_flushable,
   output logic [NCH-1:0]       done,
   output logic [31:0]          rdata,
   output logic [TAG_W-1:0]     rtag
);

   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_LAST = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_gnt;
   logic [CW-1:0]    r_rrPtr;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [1:0]       r_lastIdx;
   logic             r_we;
   logic             r_signed;
   logic             r_flushable;
   logic [TAG_W-1:0] r_tag;
   logic [1:0]       r_cnt;
   logic [23:0]      r_buf;
   logic [31:0]      r_heldA;
   logic [NCH-1:0]   r_done;
   logic [31:0]      r_rdata;
   logic [TAG_W-1:0] r_rtag;

   logic [31:0]      w_chAddr  [NCH];
   logic [31:0]      w_chWdata [NCH];
   logic [1:0]       w_chSize  [NCH];
   logic [TAG_W-1:0] w_chTag   [NCH];

   logic [NCH-1:0]   w_eligible;
   logic             w_found;
   logic [CW-1:0]    w_gnt;
   logic [CW-1:0]    w_rrNext;
   logic [1:0]       w_selLast;
   logic             w_ioStall;
   logic             w_flushKill;
   logic [31:0]      w_xferAddr;
   logic [7:0]       w_wByte;
   logic [31:0]      w_loadWord;
   logic [31:0]      w_curA;
   logic             w_curWr;
   logic [7:0]       w_curDout;

   for (genvar c = 0; c < NCH; c++) begin : g_unpack
      assign w_chAddr[c]  = req_addr[c*32 +: 32];
      assign w_chWdata[c] = req_wdata[c*32 +: 32];
      assign w_chSize[c]  = req_size[c*2 +: 2];
      assign w_chTag[c]   = req_tag[c*TAG_W +: TAG_W];
   end

   assign w_eligible = req_valid & ~({NCH{flush}} & req_flushable);

   // First eligible channel at or after the round-robin pointer wins.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_gnt   = '0;
      idx     = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(r_rrPtr) + k;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (!w_found && w_eligible[idx[CW-1:0]]) begin
            w_found = 1'b1;
            w_gnt   = idx[CW-1:0];
         end
      end
   end

   assign w_rrNext  = (w_gnt == CW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
   assign w_selLast = (w_chSize[w_gnt] == 2'd0) ? 2'd0 :
                      (w_chSize[w_gnt] == 2'd1) ? 2'd1 : 2'd3;

   assign w_ioStall   = r_we && (r_addr[17:16] == 2'b11) && io_buffer_full;
   assign w_flushKill = flush && !r_we && r_flushable &&
                        ((r_state == ST_XFER) || (r_state == ST_LAST));
   assign w_xferAddr  = r_addr + {30'd0, r_cnt};
   assign w_wByte     = 8'(r_wdata >> {r_cnt, 3'b000});

   // The final byte arrives in LAST straight from mem_din; earlier bytes come from r_buf.
   always_comb begin
      case (r_lastIdx)
         2'd0:    w_loadWord = {{24{r_signed & mem_din[7]}}, mem_din};
         2'd1:    w_loadWord = {{16{r_signed & mem_din[7]}}, mem_din, r_buf[7:0]};
         default: w_loadWord = {mem_din, r_buf[23:0]};
      endcase
   end

   always_comb begin
      w_curA    = '0;
      w_curWr   = 1'b0;
      w_curDout = '0;
      if (r_state == ST_XFER) begin
         w_curA = w_xferAddr;
         if (r_we) begin
            w_curDout = w_wByte;
            w_curWr   = !w_ioStall;
         end
      end
   end

   // While paused, keep showing the last active address so the byte the RAM returns on resume is the one owed.
   assign mem_a    = rdy ? w_curA : r_heldA;
   assign mem_wr   = rdy & w_curWr;
   assign mem_dout = w_curDout;
   assign done     = r_done;
   assign rdata    = r_rdata;
   assign rtag     = r_rtag;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_rrPtr     <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_lastIdx   <= '0;
         r_we        <= 1'b0;
         r_signed    <= 1'b0;
         r_flushable <= 1'b0;
         r_tag       <= '0;
         r_cnt       <= '0;
         r_buf       <= '0;
         r_heldA     <= '0;
         r_done      <= '0;
         r_rdata     <= '0;
         r_rtag      <= '0;
      end else if (rdy) begin
         r_done  <= '0;
         r_heldA <= w_curA;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_gnt       <= w_gnt;
                  r_addr      <= w_chAddr[w_gnt];
                  r_wdata     <= w_chWdata[w_gnt];
                  r_lastIdx   <= w_selLast;
                  r_we        <= req_we[w_gnt];
                  r_signed    <= req_signed[w_gnt];
                  r_flushable <= req_flushable[w_gnt];
                  r_tag       <= w_chTag[w_gnt];
                  r_cnt       <= '0;
                  r_rrPtr     <= w_rrNext;
                  r_state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_flushKill) begin
                  r_state <= ST_IDLE;
               end else if (!w_ioStall) begin
                  if (!r_we) begin
                     case (r_cnt)
                        2'd1:    r_buf[7:0]   <= mem_din;
                        2'd2:    r_buf[15:8]  <= mem_din;
                        2'd3:    r_buf[23:16] <= mem_din;
                        default: ;
                     endcase
                  end
                  if (r_cnt == r_lastIdx) begin
                     if (r_we) begin
                        r_state       <= ST_RESP;
                        r_done[r_gnt] <= 1'b1;
                        r_rdata       <= '0;
                        r_rtag        <= r_tag;
                     end else begin
                        r_state <= ST_LAST;
                     end
                  end else begin
                     r_cnt <= r_cnt + 2'd1;
                  end
               end
            end
            ST_LAST: begin
               if (w_flushKill) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_rdata       <= w_loadWord;
                  r_rtag        <= r_tag;
                  r_done[r_gnt] <= 1'b1;
                  r_state       <= ST_RESP;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl_multi.sv
// Testbench for mem_ctrl_multi: directed requests feed a scoreboard queue, a negedge monitor checks every done pulse.
// Also checks RAM-side address/write activity for stalls, flush, pause and reset.
module tb_mem_ctrl_multi;

   localparam int NCH   = 2;
   localparam int TAG_W = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 rdy = 1'b1;
   logic                 io_buffer_full = 1'b0;
   logic                 flush = 1'b0;
   logic [7:0]           mem_din = 8'd0;
   logic [7:0]           mem_dout;
   logic [31:0]          mem_a;
   logic                 mem_wr;
   logic [NCH-1:0]       req_valid = '0;
   logic [NCH*32-1:0]    req_addr = '0;
   logic [NCH*32-1:0]    req_wdata = '0;
   logic [NCH*2-1:0]     req_size = '0;
   logic [NCH-1:0]       req_we = '0;
   logic [NCH-1:0]       req_signed = '0;
   logic [NCH*TAG_W-1:0] req_tag = '0;
   logic [NCH-1:0]       req_flushable = '0;
   logic [NCH-1:0]       done;
   logic [31:0]          rdata;
   logic [TAG_W-1:0]     rtag;

   typedef struct {
      int               ch;
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      int               cycle;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t sbQ[$];
   wr_t  wlog[$];
   logic [7:0] ram [256];

   mem_ctrl_multi #(.NCH(NCH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .flush(flush),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_we(req_we), .req_signed(req_signed), .req_tag(req_tag), .req_flushable(req_flushable),
      .done(done), .rdata(rdata), .rtag(rtag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: one-cycle read latency, preloaded while reset is held, every write logged.
   always @(posedge clk) begin
      mem_din <= ram[mem_a[7:0]];
      if (rst) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
         ram[8'h10] <= 8'h11;
         ram[8'h11] <= 8'h22;
         ram[8'h12] <= 8'h33;
         ram[8'h13] <= 8'h44;
         ram[8'h20] <= 8'h80;
         ram[8'h22] <= 8'h34;
         ram[8'h23] <= 8'h92;
         ram[8'h40] <= 8'h5A;
         ram[8'h41] <= 8'hA5;
      end else if (mem_wr) begin
         ram[mem_a[7:0]] <= mem_dout;
         wlog.push_back('{mem_a, mem_dout});
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int ch, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic we, input logic sgn, input logic fl,
                                input logic [TAG_W-1:0] tag, input logic [31:0] expData,
                                input int lat, input logic expectDone);
      req_addr[ch*32 +: 32]       = addr;
      req_wdata[ch*32 +: 32]      = wdata;
      req_size[ch*2 +: 2]         = size;
      req_we[ch]                  = we;
      req_signed[ch]              = sgn;
      req_flushable[ch]           = fl;
      req_tag[ch*TAG_W +: TAG_W]  = tag;
      req_valid[ch]               = 1'b1;
      if (expectDone) sbQ.push_back('{ch, expData, tag, cyc + lat});
   endtask

   task automatic waitDones(input int n, input int budget);
      int seen = 0;
      for (int i = 0; i < budget && seen < n; i++) begin
         @(negedge clk);
         if (done != '0) seen++;
      end
      checkOutput("doneCount", 32'(seen), 32'(n));
      tick();
   endtask

   // Monitor: every done pulse must match the oldest scoreboard entry, including its cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (done !== '0) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'(done), 32'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("doneVec", 32'(done), 32'd1 << e.ch);
            checkOutput("rdata", rdata, e.data);
            checkOutput("rtag", 32'(rtag), 32'(e.tag));
            checkOutput("doneCycle", 32'(cyc), 32'(e.cycle));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int base;
      logic [7:0] expB [4];

      repeat (3) tick();
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstRdata", rdata, 32'd0);
      checkOutput("rstRtag", 32'(rtag), 32'd0);
      checkOutput("rstMemA", mem_a, 32'd0);
      checkOutput("rstMemWr", 32'(mem_wr), 32'd0);
      checkOutput("rstMemDout", 32'(mem_dout), 32'd0);
      rst = 1'b0;
      tick();

      // 4-byte load, address walk in cycles 1-4, done in cycle 6
      applyStimulus(0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd3, 32'h44332211, 6, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("loadAddr", mem_a, 32'h10 + 32'(k));
         checkOutput("loadWr", 32'(mem_wr), 32'd0);
      end
      waitDones(1, 12);
      req_valid[0] = 1'b0;

      // signed byte and unsigned halfword loads
      applyStimulus(1, 32'h20, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd5, 32'hFFFFFF80, 3, 1'b1);
      waitDones(1, 10);
      req_valid[1] = 1'b0;
      applyStimulus(1, 32'h22, 32'h0, 2'd1, 1'b0, 1'b0, 1'b0, 4'd6, 32'h00009234, 4, 1'b1);
      waitDones(1, 10);
      req_valid[1] = 1'b0;

      // both channels held valid: grants alternate 0,1,0,1 with done every 4 cycles
      applyStimulus(0, 32'h40, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h0000005A, 3, 1'b1);
      applyStimulus(1, 32'h41, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h000000A5, 7, 1'b1);
      sbQ.push_back('{0, 32'h0000005A, 4'd1, cyc + 11});
      sbQ.push_back('{1, 32'h000000A5, 4'd2, cyc + 15});
      waitDones(4, 30);
      req_valid = '0;

      // IO-window store stalled for 3 cycles after its first byte
      base = wlog.size();
      applyStimulus(1, 32'h00030000, 32'hDEADBEEF, 2'd2, 1'b1, 1'b0, 1'b0, 4'd7, 32'h0, 8, 1'b1);
      tick();
      checkOutput("ioWr0", 32'(mem_wr), 32'd1);
      checkOutput("ioDout0", 32'(mem_dout), 32'hEF);
      checkOutput("ioAddr0", mem_a, 32'h00030000);
      tick();
      io_buffer_full = 1'b1;
      #1;
      checkOutput("ioStallWr", 32'(mem_wr), 32'd0);
      repeat (2) begin
         tick();
         checkOutput("ioStallWr", 32'(mem_wr), 32'd0);
      end
      tick();
      io_buffer_full = 1'b0;
      #1;
      checkOutput("ioResumeWr", 32'(mem_wr), 32'd1);
      checkOutput("ioResumeDout", 32'(mem_dout), 32'hBE);
      checkOutput("ioResumeAddr", mem_a, 32'h00030001);
      waitDones(1, 12);
      req_valid[1] = 1'b0;
      expB = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      checkOutput("ioWrCount", 32'(wlog.size() - base), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (base + k < wlog.size()) begin
            checkOutput("ioWrAddr", wlog[base + k].addr, 32'h00030000 + 32'(k));
            checkOutput("ioWrData", 32'(wlog[base + k].data), 32'(expB[k]));
         end
      end

      // flush kills the flushable ch0 load at cnt=2; pending ch1 is granted in the following IDLE cycle
      applyStimulus(0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 1'b1, 4'd8, 32'h0, 0, 1'b0);
      applyStimulus(1, 32'h20, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd9, 32'hFFFFFF80, 7, 1'b1);
      tick();
      tick();
      tick();
      flush = 1'b1;
      #1;
      checkOutput("flushAddr", mem_a, 32'h12);
      tick();
      flush = 1'b0;
      req_valid[0] = 1'b0;
      req_flushable[0] = 1'b0;
      #1;
      checkOutput("flushIdleA", mem_a, 32'd0);
      checkOutput("flushIdleWr", 32'(mem_wr), 32'd0);
      tick();
      checkOutput("flushNextAddr", mem_a, 32'h20);
      waitDones(1, 10);
      req_valid[1] = 1'b0;

      // store on a flushable channel ignores flush
      base = wlog.size();
      applyStimulus(1, 32'h50, 32'h00001234, 2'd1, 1'b1, 1'b0, 1'b1, 4'd10, 32'h0, 3, 1'b1);
      tick();
      flush = 1'b1;
      #1;
      checkOutput("stFlushWr", 32'(mem_wr), 32'd1);
      checkOutput("stFlushDout0", 32'(mem_dout), 32'h34);
      tick();
      checkOutput("stFlushDout1", 32'(mem_dout), 32'h12);
      checkOutput("stFlushAddr1", mem_a, 32'h51);
      tick();
      flush = 1'b0;
      waitDones(1, 10);
      req_valid[1] = 1'b0;
      req_flushable[1] = 1'b0;
      checkOutput("stFlushCount", 32'(wlog.size() - base), 32'd2);

      // rdy low for 5 cycles at cnt=1: address frozen, result unchanged, done delayed by 5
      applyStimulus(0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd11, 32'h44332211, 11, 1'b1);
      tick();
      checkOutput("pauseAddr0", mem_a, 32'h10);
      tick();
      rdy = 1'b0;
      #1;
      checkOutput("pauseFrozenA", mem_a, 32'h10);
      checkOutput("pauseWr", 32'(mem_wr), 32'd0);
      repeat (4) begin
         tick();
         checkOutput("pauseFrozenA", mem_a, 32'h10);
      end
      tick();
      rdy = 1'b1;
      #1;
      checkOutput("pauseResumeA", mem_a, 32'h11);
      waitDones(1, 12);
      req_valid[0] = 1'b0;

      // reset during a store returns every output to its reset value
      applyStimulus(1, 32'h60, 32'hCAFEF00D, 2'd2, 1'b1, 1'b0, 1'b0, 4'd12, 32'h0, 0, 1'b0);
      tick();
      checkOutput("rstStWr", 32'(mem_wr), 32'd1);
      checkOutput("rstStDout", 32'(mem_dout), 32'h0D);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("midRstDone", 32'(done), 32'd0);
      checkOutput("midRstRdata", rdata, 32'd0);
      checkOutput("midRstRtag", 32'(rtag), 32'd0);
      checkOutput("midRstMemA", mem_a, 32'd0);
      checkOutput("midRstMemWr", 32'(mem_wr), 32'd0);
      checkOutput("midRstMemDout", 32'(mem_dout), 32'd0);
      rst = 1'b0;
      req_valid[1] = 1'b0;
      req_we[1] = 1'b0;
      repeat (4) tick();

      applyStimulus(0, 32'h40, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd13, 32'h0000005A, 3, 1'b1);
      waitDones(1, 10);
      req_valid[0] = 1'b0;
      repeat (3) tick();
      checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_multi.md
# mem_ctrl_multi

Parametrised successor to the two-client RAM controller. It arbitrates `NCH` request channels (instruction fetch, load/store buffer, and any future client such as a D-cache refill) onto the single byte-serial RAM port using round-robin arbitration. Each channel issues 1-, 2- or 4-byte loads or stores, with optional sign extension on loads. Outstanding transfers on flushable channels are aborted on mispredict, and stores to the IO window are held off while the IO buffer is full.

## Interface
- `NCH`, 2: number of request channels (≥2); channel index = bit position in the packed vectors below.
- `TAG_W`, 4: width of per-request tag (ROB id).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; low freezes the block.
- `io_buffer_full` in 1: IO write buffer full.
- `flush` in 1: mispredict; aborts flushable loads.
- `mem_din` in 8: RAM read byte; it returns the byte for the address presented in the previous cycle.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: 1 = store byte, 0 = read/idle.
- `req_valid` in NCH: request held high until the channel's `done` pulse.
- `req_addr` in NCH*32: byte address.
- `req_wdata` in NCH*32: store data, little-endian.
- `req_size` in NCH*2: 0 = 1B, 1 = 2B, 2 or 3 = 4B.
- `req_we` in NCH: 1 = store.
- `req_signed` in NCH: sign-extend load result.
- `req_tag` in NCH*TAG_W: returned with the result.
- `req_flushable` in NCH: this channel is killed by `flush`.
- `done` out NCH: one-hot, one-cycle completion pulse.
- `rdata` out 32: load result, valid with `done`.
- `rtag` out TAG_W: tag of the completed request, valid with `done`.

## Operation
- Registers:
  - state ∈ {IDLE, XFER, LAST, RESP}
  - `gnt` (channel index)
  - latched request: addr, wdata, nbytes, we, signed, tag, flushable
  - `cnt[1:0]`, `buf[23:0]`, `rr_ptr`
- IDLE:
  - Grant the first valid channel searching from `rr_ptr` upward, mod `NCH`.
  - If `flush` is high, flushable channels are excluded that cycle.
  - On grant: latch the request fields, set `cnt` = 0, set `rr_ptr` = `gnt`+1 mod `NCH`, go to XFER.
  - No RAM access in IDLE: `mem_wr` = 0, `mem_a` = 0.
- XFER:
  - Present `mem_a` = addr+`cnt` (32-bit wrap).
  - Store: `mem_wr` = 1, `mem_dout` = wdata byte `cnt`.
  - Load: for `cnt` ≥ 1, capture `mem_din` into `buf` byte `cnt`-1 at the edge.
  - `cnt` == nbytes-1 → store goes to RESP; load goes to LAST.
  - Otherwise `cnt`++.
- IO stall:
  - Applies when latched we=1, addr[17:16] == 2'b11, and `io_buffer_full` = 1.
  - XFER presents nothing (`mem_wr` = 0) and holds `cnt`.
  - Re-evaluated every cycle.
- LAST (loads only):
  - No access.
  - Capture `mem_din` as byte nbytes-1.
  - Assemble `rdata`: zero-extend, or sign-extend from bit 7 / bit 15 when signed.
  - Go to RESP.
- RESP:
  - `done[gnt]` = 1, `rtag` = latched tag, `rdata` valid (0 for stores).
  - Go to IDLE.
- Flush:
  - Applies to a `flush` edge in XFER or LAST with a latched flushable load.
  - The transfer is dropped: state → IDLE, no `done`.
  - Stores and non-flushable channels ignore `flush`.
  - Flush in RESP does not cancel the pulse.
- `rdy` = 0:
  - No register changes; `mem_a` holds its value; `mem_wr` forced to 0.
  - The RAM re-reads the held address, so the load data remains correct on resume.
- `rst` dominates `flush` and `rdy`.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` = 0, `cnt` = 0, `buf` = 0
  - `done` = 0, `rdata` = 0, `rtag` = 0
  - `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0
- Latency from the IDLE grant cycle to the `done` cycle, with `rdy` = 1 and no stall: load = nbytes+2 cycles, store = nbytes+1 cycles.
- Back-to-back requests: the cycle after RESP is IDLE, so the next grant is possible there; minimum one idle RAM cycle between transactions.
- `done`, `rdata` and `rtag` are registered outputs. The channel may drop or change `req_valid` in the cycle after `done`.
- Requests changing while not granted are legal. The latched fields are immune to request changes after grant.
- Fairness: a channel held valid is granted within `NCH` transactions.

## Test plan
- Reset, then ch0 load 4B @0x10 with RAM bytes 11,22,33,44 → `mem_a` 0x10..0x13 in cycles 1-4; `done` = 01 at cycle 6; `rdata` = 0x44332211.
- ch1 load 1B signed @0x20 = 0x80 → `rdata` = 0xFFFFFF80. Same load with 2B unsigned @0x22 = {0x34,0x92} → `rdata` = 0x00009234.
- ch0 and ch1 both valid continuously with 1B loads → grants alternate 0,1,0,1; each `done` four cycles apart.
- ch1 store 4B 0xDEADBEEF @0x30000 with `io_buffer_full` high for 3 cycles mid-transfer → no `mem_wr` during the stall; bytes EF,BE,AD,DE written in order; `done` = 10 delayed by 3 cycles.
- ch0 flushable 4B load; `flush` asserted in XFER `cnt` = 2 → no `done`; IDLE next cycle; pending ch1 granted. A store in flight under `flush` completes normally.
- `rdy` low for 5 cycles during a load at `cnt` = 1 → `mem_a` frozen, `mem_wr` = 0; on resume the result is identical to the no-pause case. `rst` mid-store → all outputs at reset values next cycle.
